lc3_execute_stage: RTL and testbench

RTL execute stage of the LC3 pipeline. It is the responder end of the execute_out bus and drives every signal that the execute_out monitor and initiator sample. It takes decoded operands and control from the decode stage and applies ALU and memory-path bypass. It registers ALU result, branch/memory address, store data and control, gated by enable_execute, for the memaccess and writeback stages.

---
 rtl/lc3_execute_stage_pkg.sv | 51 +++++
 rtl/lc3_exec_alu.sv | 46 ++++
 rtl/lc3_execute_stage.sv | 144 ++++++++++++++
 tb/tb_lc3_execute_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_execute_stage_pkg.sv
// Shared definitions for the LC3 execute stage: opcodes, control encodings and
// the E_Control field layout.
package lc3_execute_stage_pkg;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpJsr = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpRti = 4'b1000;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  typedef enum logic [1:0] {
    AluAdd  = 2'b00,
    AluAnd  = 2'b01,
    AluNot  = 2'b10,
    AluZero = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    PcOff11 = 2'b00,
    PcOff9  = 2'b01,
    PcOff6  = 2'b10,
    PcZero  = 2'b11
  } pcsel1_e;

  localparam int EcAluHi  = 5;
  localparam int EcAluLo  = 4;
  localparam int EcPc1Hi  = 3;
  localparam int EcPc1Lo  = 2;
  localparam int EcPc2    = 1;
  localparam int EcOp2Sel = 0;

  // Sign-extend the low (msb+1) bits of an IR offset field to 16 bits.
  function automatic logic [15:0] sext(input logic [10:0] field, input int msb);
    logic [15:0] res;
    res = {5'b0, field};
    for (int i = 0; i < 16; i++) begin
      if (i > msb) res[i] = res[msb];
    end
    return res;
  endfunction

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational LC3 ALU and address adder used by the execute stage.
module lc3_exec_alu
  import lc3_execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [10:0]       ir_field,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] npc,
  input  alu_ctrl_e         alu_ctrl,
  input  pcsel1_e           pcsel1,
  input  logic              pcsel2,
  input  logic              op2sel,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] addr_result
);

  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] addend_a;
  logic [DATA_W-1:0] addend_b;

  always_comb begin
    op2 = op2sel ? val2 : sext(ir_field, 4);
    alu_result = '0;
    case (alu_ctrl)
      AluAdd:  alu_result = val1 + op2;
      AluAnd:  alu_result = val1 & op2;
      AluNot:  alu_result = ~val1;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    addend_a = '0;
    case (pcsel1)
      PcOff11: addend_a = sext(ir_field, 10);
      PcOff9:  addend_a = sext(ir_field, 8);
      PcOff6:  addend_a = sext(ir_field, 5);
      default: addend_a = '0;
    endcase
    addend_b    = pcsel2 ? npc : val1;
    addr_result = addend_a + addend_b;
  end

endmodule

// File: rtl/lc3_execute_stage.sv
// LC3 execute stage: operand bypass muxes, ALU/address adder and the
// execute-to-memaccess pipeline register.
module lc3_execute_stage
  import lc3_execute_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  input  logic [1:0]  W_Control_in,
  input  logic        Mem_Control_in,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] IR_Exec,
  output logic [2:0]  NZP,
  output logic [15:0] M_Data,
  output logic        enable_execute_status
);

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] m_data_q, m_data_d;
  logic [1:0]  w_ctrl_q, w_ctrl_d;
  logic        mem_ctrl_q, mem_ctrl_d;
  logic        en_status_q, en_status_d;

  logic [15:0] val1, val2;
  logic [15:0] alu_result, addr_result;
  logic [2:0]  dr_dec, nzp_dec;

  // ALU bypass takes the registered result so dependent ops chain every cycle.
  always_comb begin
    val1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    val2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
  end

  lc3_exec_alu #(
    .DATA_W(16)
  ) u_alu (
    .ir_field   (IR[10:0]),
    .val1       (val1),
    .val2       (val2),
    .npc        (npc_in),
    .alu_ctrl   (alu_ctrl_e'(E_Control[EcAluHi:EcAluLo])),
    .pcsel1     (pcsel1_e'(E_Control[EcPc1Hi:EcPc1Lo])),
    .pcsel2     (E_Control[EcPc2]),
    .op2sel     (E_Control[EcOp2Sel]),
    .alu_result (alu_result),
    .addr_result(addr_result)
  );

  always_comb begin
    nzp_dec = 3'b000;
    dr_dec  = IR[11:9];
    case (IR[15:12])
      OpBr: begin
        nzp_dec = IR[11:9];
        dr_dec  = 3'b000;
      end
      OpJmp: begin
        nzp_dec = 3'b111;
        dr_dec  = 3'b000;
      end
      OpSt, OpStr, OpSti: dr_dec = 3'b000;
      default: ;
    endcase
  end

  always_comb begin
    aluout_d    = aluout_q;
    pcout_d     = pcout_q;
    dr_d        = dr_q;
    ir_d        = ir_q;
    nzp_d       = nzp_q;
    m_data_d    = m_data_q;
    w_ctrl_d    = w_ctrl_q;
    mem_ctrl_d  = mem_ctrl_q;
    en_status_d = enable_execute;
    if (enable_execute) begin
      aluout_d   = alu_result;
      pcout_d    = addr_result;
      dr_d       = dr_dec;
      ir_d       = IR;
      nzp_d      = nzp_dec;
      m_data_d   = val2;
      w_ctrl_d   = W_Control_in;
      mem_ctrl_d = Mem_Control_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout_q    <= '0;
      pcout_q     <= '0;
      dr_q        <= '0;
      ir_q        <= '0;
      nzp_q       <= '0;
      m_data_q    <= '0;
      w_ctrl_q    <= '0;
      mem_ctrl_q  <= 1'b0;
      en_status_q <= 1'b0;
    end else begin
      aluout_q    <= aluout_d;
      pcout_q     <= pcout_d;
      dr_q        <= dr_d;
      ir_q        <= ir_d;
      nzp_q       <= nzp_d;
      m_data_q    <= m_data_d;
      w_ctrl_q    <= w_ctrl_d;
      mem_ctrl_q  <= mem_ctrl_d;
      en_status_q <= en_status_d;
    end
  end

  assign aluout                = aluout_q;
  assign pcout                 = pcout_q;
  assign dr                    = dr_q;
  assign IR_Exec               = ir_q;
  assign NZP                   = nzp_q;
  assign M_Data                = m_data_q;
  assign W_Control_out         = w_ctrl_q;
  assign Mem_Control_out       = mem_ctrl_q;
  assign enable_execute_status = en_status_q;
  assign sr1                   = IR[8:6];
  assign sr2                   = IR[2:0];

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Directed plus randomized bench for lc3_execute_stage against an arithmetic
// reference model of the LC3 execute rules.
module tb_lc3_execute_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_execute = 1'b0;
  logic [5:0]  E_Control = '0;
  logic [15:0] IR = '0, npc_in = '0, VSR1 = '0, VSR2 = '0, Mem_Bypass_Val = '0;
  logic        bypass_alu_1 = 1'b0, bypass_alu_2 = 1'b0;
  logic        bypass_mem_1 = 1'b0, bypass_mem_2 = 1'b0;
  logic [1:0]  W_Control_in = '0;
  logic        Mem_Control_in = 1'b0;

  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [15:0] aluout, pcout, IR_Exec, M_Data;
  logic [2:0]  dr, sr1, sr2, NZP;
  logic        enable_execute_status;

  lc3_execute_stage dut (
    .clock                (clock),
    .reset                (reset),
    .enable_execute       (enable_execute),
    .E_Control            (E_Control),
    .IR                   (IR),
    .npc_in               (npc_in),
    .VSR1                 (VSR1),
    .VSR2                 (VSR2),
    .bypass_alu_1         (bypass_alu_1),
    .bypass_alu_2         (bypass_alu_2),
    .bypass_mem_1         (bypass_mem_1),
    .bypass_mem_2         (bypass_mem_2),
    .Mem_Bypass_Val       (Mem_Bypass_Val),
    .W_Control_in         (W_Control_in),
    .Mem_Control_in       (Mem_Control_in),
    .W_Control_out        (W_Control_out),
    .Mem_Control_out      (Mem_Control_out),
    .aluout               (aluout),
    .pcout                (pcout),
    .dr                   (dr),
    .sr1                  (sr1),
    .sr2                  (sr2),
    .IR_Exec              (IR_Exec),
    .NZP                  (NZP),
    .M_Data               (M_Data),
    .enable_execute_status(enable_execute_status)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state: what each registered output should hold.
  logic [15:0] m_alu, m_pc, m_ir, m_mdata;
  logic [2:0]  m_dr, m_nzp;
  logic [1:0]  m_wc;
  logic        m_mc, m_en;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".aluout"}, aluout, m_alu);
    chk({tag, ".pcout"}, pcout, m_pc);
    chk({tag, ".IR_Exec"}, IR_Exec, m_ir);
    chk({tag, ".M_Data"}, M_Data, m_mdata);
    chk({tag, ".dr"}, 16'(dr), 16'(m_dr));
    chk({tag, ".NZP"}, 16'(NZP), 16'(m_nzp));
    chk({tag, ".W_Control_out"}, 16'(W_Control_out), 16'(m_wc));
    chk({tag, ".Mem_Control_out"}, 16'(Mem_Control_out), 16'(m_mc));
    chk({tag, ".enable_status"}, 16'(enable_execute_status), 16'(m_en));
  endtask

  function automatic int signed_field(input int value, input int bits);
    int span;
    span = 1 << bits;
    value = value % span;
    return (value >= span / 2) ? value - span : value;
  endfunction

  // Expected next-state from the architectural rules, using integer arithmetic.
  task automatic model_update();
    int v1, v2, op2, a, b, op;
    v1 = bypass_alu_1 ? int'(m_alu) : (bypass_mem_1 ? int'(Mem_Bypass_Val) : int'(VSR1));
    v2 = bypass_alu_2 ? int'(m_alu) : (bypass_mem_2 ? int'(Mem_Bypass_Val) : int'(VSR2));
    op2 = E_Control[0] ? v2 : signed_field(int'(IR) % 32, 5);
    op = int'(IR) / 4096;
    m_en = enable_execute;
    if (!enable_execute) return;
    case (int'(E_Control) / 16)
      0: m_alu = 16'(v1 + op2);
      1: m_alu = 16'(v1) & 16'(op2);
      2: m_alu = 16'(65535 - v1);
      default: m_alu = 16'(0);
    endcase
    case ((int'(E_Control) / 4) % 4)
      0: a = signed_field(int'(IR) % 2048, 11);
      1: a = signed_field(int'(IR) % 512, 9);
      2: a = signed_field(int'(IR) % 64, 6);
      default: a = 0;
    endcase
    b = E_Control[1] ? int'(npc_in) : v1;
    m_pc = 16'(a + b);
    m_mdata = 16'(v2);
    m_ir = IR;
    m_wc = W_Control_in;
    m_mc = Mem_Control_in;
    m_nzp = 3'd0;
    m_dr = 3'((int'(IR) / 512) % 8);
    if (op == 0) begin
      m_nzp = m_dr;
      m_dr = 3'd0;
    end else if (op == 12) begin
      m_nzp = 3'd7;
      m_dr = 3'd0;
    end else if (op == 3 || op == 7 || op == 11) begin
      m_dr = 3'd0;
    end
  endtask

  task automatic model_reset();
    m_alu = '0; m_pc = '0; m_ir = '0; m_mdata = '0;
    m_dr = '0; m_nzp = '0; m_wc = '0; m_mc = 1'b0; m_en = 1'b0;
  endtask

  // Inputs were driven just after a rising edge; check sr fields, clock, check all.
  task automatic step(input string tag);
    #1;
    chk({tag, ".sr1"}, 16'(sr1), 16'((int'(IR) / 64) % 8));
    chk({tag, ".sr2"}, 16'(sr2), 16'(int'(IR) % 8));
    model_update();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic clear_bypass();
    bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    check_all("reset_hold");

    enable_execute = 1;
    IR = 16'h1283; VSR1 = 16'd5; VSR2 = 16'd7; E_Control = 6'b000001;
    step("add_reg");
    chk("add_reg.const", aluout, 16'h000C);

    IR = 16'h1261; E_Control = 6'b000000; VSR1 = 16'hDEAD;
    bypass_alu_1 = 1; bypass_mem_1 = 1; Mem_Bypass_Val = 16'h0100;
    step("byp_alu_prio");
    chk("byp_alu_prio.const", aluout, 16'h000D);

    bypass_alu_1 = 0;
    step("byp_mem");
    chk("byp_mem.const", aluout, 16'h0101);
    clear_bypass();

    IR = 16'h12BF; VSR1 = 16'h0000; E_Control = 6'b000000;
    step("add_imm_m1");
    chk("add_imm_m1.const", aluout, 16'hFFFF);

    VSR1 = 16'h00FF; E_Control = 6'b100000;
    step("not");
    chk("not.const", aluout, 16'hFF00);

    IR = 16'h05FE; npc_in = 16'h3001; E_Control = 6'b000110;
    step("brz");
    chk("brz.const_pc", pcout, 16'h2FFF);
    chk("brz.const_nzp", 16'(NZP), 16'(3'b010));

    IR = 16'h7283; VSR2 = 16'h1111; bypass_mem_2 = 1; Mem_Bypass_Val = 16'h2222;
    E_Control = 6'b001000; W_Control_in = 2'b10; Mem_Control_in = 1;
    step("str");
    chk("str.const_mdata", M_Data, 16'h2222);
    clear_bypass();

    IR = 16'hC1C0; E_Control = 6'b111100;
    step("jmp");

    enable_execute = 0;
    for (int i = 0; i < 3; i++) begin
      IR = 16'($urandom); VSR1 = 16'($urandom); VSR2 = 16'($urandom);
      E_Control = 6'($urandom); npc_in = 16'($urandom);
      W_Control_in = 2'($urandom); Mem_Control_in = 1'($urandom);
      step($sformatf("stall%0d", i));
    end

    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      enable_execute = ($urandom_range(9) != 0);
      IR = 16'($urandom); VSR1 = 16'($urandom); VSR2 = 16'($urandom);
      npc_in = 16'($urandom); Mem_Bypass_Val = 16'($urandom);
      E_Control = 6'($urandom);
      bypass_alu_1 = ($urandom_range(3) == 0); bypass_alu_2 = ($urandom_range(3) == 0);
      bypass_mem_1 = ($urandom_range(3) == 0); bypass_mem_2 = ($urandom_range(3) == 0);
      W_Control_in = 2'($urandom); Mem_Control_in = 1'($urandom);
      step($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
